ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Receives raw PS/2 keyboard frames and turns them into decoded key events: a one-cycle `scan_received` strobe with `scancode`, `extended` and `released`. It sits directly upstream of the Spectrum key-matrix translator, the key-status tracker and the special-function decoder, and drives all three from the same event bus. All logic runs in the keyboard clock domain. The PS/2 clock and data lines are asynchronous inputs.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronised samples needed to accept a new PS/2 clock level.
- `TIMEOUT`, default 28000: system cycles without an accepted falling edge before a partial frame is abandoned (about 1 ms at 28 MHz).
- `clk` input 1: system clock; the same clock the keyboard consumers use.
- `rst_n` input 1: reset; one clock, asynchronous assert, active-low.
- `ps2clk` input 1: raw PS/2 clock line (asynchronous).
- `ps2data` input 1: raw PS/2 data line (asynchronous).
- `scan_received` output 1: one-cycle strobe; a key event is valid.
- `scancode` output 8: key code with the prefixes stripped. It is held until the next event.
- `extended` output 1: an E0 prefix preceded this code. Held with `scancode`.
- `released` output 1: an F0 prefix preceded this code. Held with `scancode`.
- `frame_error` output 1: one-cycle strobe; a frame was dropped because of parity, stop-bit or timeout.

## Operation
- **Input conditioning**
  - `ps2clk` and `ps2data` each pass through a 2-flop synchroniser.
  - The clock then goes through a FILTER_LEN glitch filter.
  - A filtered high-to-low transition is an accepted falling edge. Data is sampled on that edge.
- **Receiver FSM**
  - Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
  - IDLE: on an edge with data 0, go to DATA. An edge with data 1 is ignored; stay in IDLE.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP:
    - If data is 1 and parity is good, raise the internal `byte_valid` for 1 cycle.
    - Otherwise pulse `frame_error`.
    - Go to IDLE in either case.
  - Timeout: a counter clears on every accepted edge. If it reaches TIMEOUT in any state other than IDLE, return to IDLE, clear the bit count and pulse `frame_error`.
- **Prefix decoder** (runs on `byte_valid`)
  - E0: set `ext_pend`.
  - F0: set `brk_pend`.
  - E1: load `pause_cnt`=7. This byte and the next 7 valid bytes are discarded and no event is produced.
  - 00 and FF (keyboard overrun): discarded. Pending flags are kept.
  - Any other byte:
    - Load `scancode`=byte, `extended`=`ext_pend`, `released`=`brk_pend`.
    - Pulse `scan_received`.
    - Clear both pending flags.
- While `pause_cnt` is nonzero, each valid byte decrements it and nothing else happens.

## Timing
- Reset values: all outputs 0; receiver in IDLE; pending flags 0; `pause_cnt` 0; timeout counter 0.
- Reset mid-frame discards the partial frame. No strobe is issued on reset exit.
- Edge latency: 2 synchroniser cycles plus FILTER_LEN cycles from a pin transition to the accepted edge.
- `byte_valid` asserts 1 cycle after the stop-bit edge is accepted.
- `scan_received` asserts 1 cycle after `byte_valid`. `scancode`, `extended` and `released` update in that same cycle.
- `frame_error` from a stop or parity failure asserts 1 cycle after the stop-bit edge is accepted.
- Back-to-back events are at least 11 PS/2 bit times apart. There is no backpressure, and consumers must accept every strobe.
- If timeout expiry and an accepted edge fall in the same cycle, the edge wins and the counter clears.
- A frame error does not clear `ext_pend`, `brk_pend` or `pause_cnt`.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a parity mismatch drops the frame and pulses `frame_error`.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled but ignored. Only stop-bit and timeout failures raise `frame_error`.

## Structure
- Package `ps2_pkg` holds:
  - the prefix constants E0, F0, E1 and the overrun codes 00 and FF;
  - the receiver state enum (IDLE, DATA, PARITY, STOP);
  - the pause-sequence length constant, 7.
- Sub-module `ps2_rx_frame` contains the synchroniser, the filter, the receiver FSM and the timeout counter. It outputs `byte_valid`, `byte[7:0]` and `frame_error`.
- The top level contains the prefix decoder and the output registers.

## Test plan
- Frame 0x1C with correct parity -> one `scan_received` pulse; `scancode`=0x1C, `extended`=0, `released`=0; `frame_error` stays 0.
- Frames E0, F0, 0x75 -> exactly one pulse; `scancode`=0x75, `extended`=1, `released`=1. Follow with 0x1C -> `extended`=0, `released`=0.
- Frame 0x1C with a wrong parity bit:
  - with `PS2_PARITY_CHECK_EN`: no `scan_received`, one `frame_error` pulse;
  - without the macro: a normal 0x1C event.
- Stop after 4 data bits, idle TIMEOUT+1 cycles, then send frame 0x29 -> one `frame_error` pulse, then a clean 0x29 event.
- Sequence E1 14 77 E1 F0 14 F0 77, then 0x1C -> no event during the pause sequence; a single 0x1C event with both flags 0.
- Assert `rst_n` low after 5 bits of a frame, release it, then send 0x16 -> outputs are 0 during reset, no spurious strobe, and a clean 0x16 event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scancode decoder: prefix codes,
// overrun codes, receiver state encoding and pause-sequence length.
package ps2_pkg;

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodePause = 8'hE1;
  localparam logic [7:0] CodeOvr00 = 8'h00;
  localparam logic [7:0] CodeOvrFF = 8'hFF;

  // Bytes swallowed after the E1 that opens the Pause/Break sequence.
  localparam int unsigned PauseLen  = 7;
  localparam int unsigned PauseCntW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, framing FSM and timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 28000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       byte_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       frame_error_o
);
  import ps2_pkg::*;

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  // Bit [1] of each pair is the synchronised value; idle line level is high.
  logic [1:0]      clk_sync_q, data_sync_q;
  logic            filt_level_q, filt_level_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic            fall_edge, din;

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_expire, parity_ok;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_error_q, frame_error_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_level_q <= 1'b1;
      filt_cnt_q   <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2clk_i};
      data_sync_q  <= {data_sync_q[0], ps2data_i};
      filt_level_q <= filt_level_d;
      filt_cnt_q   <= filt_cnt_d;
    end
  end

  // A new level is taken only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_level_d = filt_level_q;
    filt_cnt_d   = '0;
    if (clk_sync_q[1] != filt_level_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_level_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall_edge = filt_level_q & ~filt_level_d;
  assign din       = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign parity_ok     = 1'b1;
`endif

  assign tmo_expire = (state_q != StIdle) && !fall_edge && (tmo_cnt_q == TmoW'(TIMEOUT));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo_expire) begin
      state_d = StIdle;
    end else if (fall_edge) begin
      unique case (state_q)
        StIdle:   if (!din) state_d = StData;
        StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs: result strobes are registered, so they land one cycle after the stop edge.
  always_comb begin
    byte_valid_d  = 1'b0;
    frame_error_d = tmo_expire;
    if (fall_edge && state_q == StStop) begin
      byte_valid_d  = din & parity_ok;
      frame_error_d = ~(din & parity_ok);
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (fall_edge || state_q == StIdle || tmo_expire) begin
      tmo_cnt_d = '0;
    end
    if (tmo_expire) begin
      bit_cnt_d = '0;
    end else if (fall_edge) begin
      if (state_q == StIdle) begin
        bit_cnt_d = '0;
      end else if (state_q == StData) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = {din, shift_q[7:1]};
      end else if (state_q == StParity) begin
        parity_d = din;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_valid_o  = byte_valid_q;
  assign rx_byte_o     = shift_q;
  assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard decoder top: frame receiver plus E0/F0/E1 prefix handling into key events.
// Optional macro PS2_PARITY_CHECK_EN makes parity failures drop the frame.
module ps2_scancode_decoder #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 28000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       scan_received,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);
  import ps2_pkg::*;

  logic       byte_valid;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ps2clk_i     (ps2clk),
    .ps2data_i    (ps2data),
    .byte_valid_o (byte_valid),
    .rx_byte_o    (rx_byte),
    .frame_error_o(frame_error)
  );

  logic                 scan_received_q, scan_received_d;
  logic [7:0]           scancode_q, scancode_d;
  logic                 extended_q, extended_d;
  logic                 released_q, released_d;
  logic                 ext_pend_q, ext_pend_d;
  logic                 brk_pend_q, brk_pend_d;
  logic [PauseCntW-1:0] pause_cnt_q, pause_cnt_d;

  always_comb begin
    scan_received_d = 1'b0;
    scancode_d      = scancode_q;
    extended_d      = extended_q;
    released_d      = released_q;
    ext_pend_d      = ext_pend_q;
    brk_pend_d      = brk_pend_q;
    pause_cnt_d     = pause_cnt_q;
    if (byte_valid) begin
      if (pause_cnt_q != '0) begin
        pause_cnt_d = pause_cnt_q - 1'b1;
      end else begin
        case (rx_byte)
          CodeExt:   ext_pend_d  = 1'b1;
          CodeBrk:   brk_pend_d  = 1'b1;
          CodePause: pause_cnt_d = PauseCntW'(PauseLen);
          // Overrun markers carry no key; keep any pending prefixes.
          CodeOvr00, CodeOvrFF: begin
          end
          default: begin
            scan_received_d = 1'b1;
            scancode_d      = rx_byte;
            extended_d      = ext_pend_q;
            released_d      = brk_pend_q;
            ext_pend_d      = 1'b0;
            brk_pend_d      = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_received_q <= 1'b0;
      scancode_q      <= '0;
      extended_q      <= 1'b0;
      released_q      <= 1'b0;
      ext_pend_q      <= 1'b0;
      brk_pend_q      <= 1'b0;
      pause_cnt_q     <= '0;
    end else begin
      scan_received_q <= scan_received_d;
      scancode_q      <= scancode_d;
      extended_q      <= extended_d;
      released_q      <= released_d;
      ext_pend_q      <= ext_pend_d;
      brk_pend_q      <= brk_pend_d;
      pause_cnt_q     <= pause_cnt_d;
    end
  end

  assign scan_received = scan_received_q;
  assign scancode      = scancode_q;
  assign extended      = extended_q;
  assign released      = released_q;

endmodule
